// File: rtl/contador_rfwild_monitor_if.sv
// rtl/contador_rfwild_monitor_if.sv - counter-under-test and status bus for the sequence monitor
interface contador_rfwild_monitor_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0] contador;
  logic             en;
  logic             clear_err;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_cnt;
  logic [WIDTH-1:0] expected;

  modport master (
    output contador, en, clear_err,
    input  locked, err_pulse, err_sticky, err_cnt, expected
  );

  modport slave (
    input  contador, en, clear_err,
    output locked, err_pulse, err_sticky, err_cnt, expected
  );
endinterface

// File: rtl/contador_rfwild_monitor.sv
// rtl/contador_rfwild_monitor.sv - locks onto a +STEP counter sequence and counts breaks in it
module contador_rfwild_monitor #(
  parameter int WIDTH    = 4,
  parameter int STEP     = 1,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  contador_rfwild_monitor_if.slave bus
);

  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] next_ref;
  logic [MW-1:0]    match_inc;
  logic             hit;
  logic             err_detect;

  // Truncation to WIDTH makes the wrap from all-ones back to zero a legal step.
  assign next_ref  = bus.contador + WIDTH'(STEP);
  assign match_inc = match_cnt_q + MW'(1);
  assign hit       = (bus.contador == ref_q);

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    match_cnt_d = match_cnt_q;
    err_detect  = 1'b0;
    if (bus.en) begin
      ref_d = next_ref;
      case (state_q)
        SEARCH: begin
          match_cnt_d = '0;
          state_d     = ACQUIRE;
        end
        ACQUIRE: begin
          if (hit) begin
            if (match_inc == MW'(LOCK_CNT)) begin
              match_cnt_d = '0;
              state_d     = LOCKED;
            end else begin
              match_cnt_d = match_inc;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!hit) begin
            err_detect  = 1'b1;
            match_cnt_d = '0;
            state_d     = ACQUIRE;
          end
        end
        default: begin
          match_cnt_d = '0;
          state_d     = SEARCH;
        end
      endcase
    end
  end

  // A clear and an error on the same edge leave a count of one: the error lands after the clear.
  always_comb begin
    err_pulse_d  = err_detect;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (bus.clear_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end
    if (err_detect) begin
      err_sticky_d = 1'b1;
      if (bus.clear_err) begin
        err_cnt_d = ERR_W'(1);
      end else if (!(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SEARCH;
      ref_q        <= '0;
      match_cnt_q  <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      match_cnt_q  <= match_cnt_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.locked     = (state_q == LOCKED);
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.expected   = ref_q;

endmodule

// File: tb/tb_contador_rfwild_monitor.sv
// tb/tb_contador_rfwild_monitor.sv - directed self-checking bench for the counter sequence monitor
module tb_contador_rfwild_monitor;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  contador_rfwild_monitor_if #(.WIDTH(4), .ERR_W(8)) bus ();

  contador_rfwild_monitor #(
    .WIDTH(4), .STEP(1), .LOCK_CNT(3), .ERR_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge with the given inputs; outputs are sampled 1 time unit after it.
  task automatic drive(input logic [3:0] v, input logic e, input logic clr);
    bus.contador  = v;
    bus.en        = e;
    bus.clear_err = clr;
    @(posedge clk);
    #1;
    bus.clear_err = 1'b0;
  endtask

  task automatic test_reset;
    reset         = 1'b0;
    bus.contador  = 4'd0;
    bus.en        = 1'b0;
    bus.clear_err = 1'b0;
    #3;
    total++;
    if ({bus.locked, bus.err_pulse, bus.err_sticky} !== 3'b000 || bus.err_cnt !== 8'd0 || bus.expected !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: locked=%b pulse=%b sticky=%b cnt=%0d exp=%0d required all zero",
               bus.locked, bus.err_pulse, bus.err_sticky, bus.err_cnt, bus.expected);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_lock;
    for (int i = 0; i < 4; i++) begin
      drive(4'(i), 1'b1, 1'b0);
      if (i < 3) begin
        total++;
        if (bus.locked !== 1'b0) begin
          bad++;
          $display("FAIL lock_early_%0d: locked=%b required 0", i, bus.locked);
        end
      end
    end
    total++;
    if (bus.locked !== 1'b1 || bus.expected !== 4'd4 || bus.err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL lock_acquired: locked=%b exp=%0d cnt=%0d required 1/4/0",
               bus.locked, bus.expected, bus.err_cnt);
    end
  endtask

  task automatic test_wrap;
    int pulses;
    pulses = 0;
    for (int v = 4; v < 18; v++) begin
      drive(4'(v), 1'b1, 1'b0);
      if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0 || bus.expected !== 4'd2 || bus.err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL wrap_legal: disturbances=%0d exp=%0d sticky=%b required 0/2/0",
               pulses, bus.expected, bus.err_sticky);
    end
  endtask

  task automatic test_error_relock;
    for (int v = 2; v < 6; v++) drive(4'(v), 1'b1, 1'b0);
    drive(4'd7, 1'b1, 1'b0);
    total++;
    if (bus.err_pulse !== 1'b1 || bus.err_cnt !== 8'd1 || bus.err_sticky !== 1'b1 ||
        bus.locked !== 1'b0 || bus.expected !== 4'd8) begin
      bad++;
      $display("FAIL error_detect: pulse=%b cnt=%0d sticky=%b locked=%b exp=%0d required 1/1/1/0/8",
               bus.err_pulse, bus.err_cnt, bus.err_sticky, bus.locked, bus.expected);
    end
    drive(4'd8, 1'b1, 1'b0);
    total++;
    if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b0 || bus.err_cnt !== 8'd1) begin
      bad++;
      $display("FAIL error_pulse_width: pulse=%b locked=%b cnt=%0d required 0/0/1",
               bus.err_pulse, bus.locked, bus.err_cnt);
    end
    drive(4'd9, 1'b1, 1'b0);
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL relock_early: locked=%b required 0", bus.locked);
    end
    drive(4'd10, 1'b1, 1'b0);
    total++;
    if (bus.locked !== 1'b1 || bus.expected !== 4'd11 || bus.err_sticky !== 1'b1) begin
      bad++;
      $display("FAIL relock: locked=%b exp=%0d sticky=%b required 1/11/1",
               bus.locked, bus.expected, bus.err_sticky);
    end
  endtask

  task automatic test_hold;
    logic [3:0] junk [5];
    int         drift;
    junk  = '{4'd3, 4'd0, 4'd15, 4'd7, 4'd12};
    drift = 0;
    for (int i = 0; i < 5; i++) begin
      drive(junk[i], 1'b0, 1'b0);
      if (bus.expected !== 4'd11 || bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) drift++;
    end
    total++;
    if (drift !== 0) begin
      bad++;
      $display("FAIL hold_en_low: disturbed cycles=%0d required 0", drift);
    end
    drive(4'd11, 1'b1, 1'b0);
    total++;
    if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b1 || bus.expected !== 4'd12 || bus.err_cnt !== 8'd1) begin
      bad++;
      $display("FAIL hold_resume: pulse=%b locked=%b exp=%0d cnt=%0d required 0/1/12/1",
               bus.err_pulse, bus.locked, bus.expected, bus.err_cnt);
    end
  endtask

  task automatic test_clear;
    drive(4'd0, 1'b1, 1'b1);
    total++;
    if (bus.err_cnt !== 8'd1 || bus.err_sticky !== 1'b1 || bus.err_pulse !== 1'b1 || bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL clear_with_error: cnt=%0d sticky=%b pulse=%b locked=%b required 1/1/1/0",
               bus.err_cnt, bus.err_sticky, bus.err_pulse, bus.locked);
    end
    for (int v = 1; v < 4; v++) drive(4'(v), 1'b1, 1'b0);
    drive(4'd9, 1'b0, 1'b1);
    total++;
    if (bus.err_cnt !== 8'd0 || bus.err_sticky !== 1'b0 || bus.locked !== 1'b1 || bus.expected !== 4'd4) begin
      bad++;
      $display("FAIL clear_alone: cnt=%0d sticky=%b locked=%b exp=%0d required 0/0/1/4",
               bus.err_cnt, bus.err_sticky, bus.locked, bus.expected);
    end
  endtask

  task automatic test_saturate_and_reset;
    logic [3:0] r;
    logic [3:0] b;
    int         pulses;
    r      = 4'd4;
    pulses = 0;
    for (int k = 0; k < 260; k++) begin
      b = r + 4'd5;
      drive(b, 1'b1, 1'b0);
      if (bus.err_pulse === 1'b1) pulses++;
      r = b + 4'd1;
      for (int j = 0; j < 3; j++) begin
        drive(r, 1'b1, 1'b0);
        r = r + 4'd1;
      end
    end
    total++;
    if (pulses !== 260) begin
      bad++;
      $display("FAIL sat_pulses: pulses=%0d required 260", pulses);
    end
    total++;
    if (bus.err_cnt !== 8'd255 || bus.err_sticky !== 1'b1 || bus.locked !== 1'b1 || bus.expected !== r) begin
      bad++;
      $display("FAIL sat_count: cnt=%0d sticky=%b locked=%b exp=%0d required 255/1/1/%0d",
               bus.err_cnt, bus.err_sticky, bus.locked, bus.expected, r);
    end
    drive(r + 4'd3, 1'b1, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.locked, bus.err_pulse, bus.err_sticky} !== 3'b000 || bus.err_cnt !== 8'd0 || bus.expected !== 4'd0) begin
      bad++;
      $display("FAIL async_reset: locked=%b pulse=%b sticky=%b cnt=%0d exp=%0d required all zero",
               bus.locked, bus.err_pulse, bus.err_sticky, bus.err_cnt, bus.expected);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    drive(4'd9, 1'b1, 1'b0);
    total++;
    if (bus.locked !== 1'b0 || bus.expected !== 4'd10 || bus.err_pulse !== 1'b0 || bus.err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL post_reset_search: locked=%b exp=%0d pulse=%b cnt=%0d required 0/10/0/0",
               bus.locked, bus.expected, bus.err_pulse, bus.err_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_lock();
    test_wrap();
    test_error_relock();
    test_hold();
    test_clear();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
